// File: rtl/s2_pkg.sv
// Shared types and default geometry for the S2 frame receiver.
// Optional readback check is enabled by defining RB2_VERIFY_EN.
package s2_pkg;
  localparam int DEF_NWORD  = 18;
  localparam int DEF_WIDTH  = 8;
  localparam int DEF_ABITS  = 3;
  localparam int FRAME_BITS = DEF_ABITS + DEF_NWORD;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    VERIFY,
    DONE
  } state_t;
endpackage

// File: rtl/s2_frame_deser.sv
// Serial-to-parallel front end: collects ABITS+NWORD bits while sen is low and
// pulses frame_valid for one cycle after the last bit; short frames are dropped.
module s2_frame_deser #(
  parameter int NWORD = 18,
  parameter int ABITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sen,
  input  logic             sd,
  output logic             frame_valid,
  output logic [ABITS-1:0] addr,
  output logic [NWORD-1:0] data
);
  localparam int FB = ABITS + NWORD;
  localparam int CW = $clog2(FB + 1);

  logic [FB-1:0] sr;
  logic [CW-1:0] cnt;

  // cnt saturates at FB so trailing bits of an overlong frame are ignored
  // until sen goes high and clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt         <= '0;
      sr          <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (sen) begin
        cnt <= '0;
      end else if (cnt < CW'(FB)) begin
        sr  <= {sr[FB-2:0], sd};
        cnt <= cnt + 1'b1;
        if (cnt == CW'(FB - 1)) frame_valid <= 1'b1;
      end
    end
  end

  assign addr = sr[FB-1 -: ABITS];

  // b0 arrives first, so it sits deepest in the shift register.
  always_comb begin
    data = '0;
    for (int j = 0; j < NWORD; j++) data[j] = sr[NWORD-1-j];
  end
endmodule

// File: rtl/s2_frame_receiver.sv
// Reassembles column frames into NWORD bytes and writes them to RB2, then raises done.
// Define RB2_VERIFY_EN to read RB2 back and flag mismatches on err.
module s2_frame_receiver
  import s2_pkg::*;
#(
  parameter int NWORD = DEF_NWORD,
  parameter int WIDTH = DEF_WIDTH,
  parameter int ABITS = DEF_ABITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sen,
  input  logic             sd,
  output logic             RB2_RW,
  output logic [4:0]       RB2_A,
  output logic [WIDTH-1:0] RB2_D,
  input  logic [WIDTH-1:0] RB2_Q,
  output logic             done,
  output logic             err
);
  state_t             state;
  logic               f_valid;
  logic [ABITS-1:0]   f_addr;
  logic [NWORD-1:0]   f_data;
  logic [ABITS-1:0]   bit_sel;
  logic [WIDTH-1:0]   mask;
  logic [WIDTH-1:0]   mask_nxt;
  logic [WIDTH-1:0]   word0_new;
  logic [WIDTH-1:0]   col_buf [NWORD];

  s2_frame_deser #(.NWORD(NWORD), .ABITS(ABITS)) u_deser (
    .clk         (clk),
    .rst         (rst),
    .sen         (sen),
    .sd          (sd),
    .frame_valid (f_valid),
    .addr        (f_addr),
    .data        (f_data)
  );

  // Column k carries bit WIDTH-1-k of every word.
  assign bit_sel = ABITS'(WIDTH - 1) - f_addr;

  always_comb begin
    mask_nxt         = mask;
    mask_nxt[f_addr] = 1'b1;
    word0_new          = col_buf[0];
    word0_new[bit_sel] = f_data[0];
  end

  always_ff @(posedge clk) begin
    if (f_valid && (state == IDLE || state == RECV)) begin
      for (int j = 0; j < NWORD; j++) col_buf[j][bit_sel] <= f_data[j];
    end
  end

`ifdef RB2_VERIFY_EN
  logic [4:0] vcnt;
`else
  wire unused_q = ^RB2_Q;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      mask   <= '0;
      RB2_RW <= 1'b1;
      RB2_A  <= '0;
      RB2_D  <= '0;
      done   <= 1'b0;
`ifdef RB2_VERIFY_EN
      err    <= 1'b0;
      vcnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE, RECV: begin
          if (f_valid) begin
            mask <= mask_nxt;
            // Word 0 is launched on the commit edge, so it needs the new column merged in.
            if (&mask_nxt) begin
              state  <= WRITE;
              RB2_RW <= 1'b0;
              RB2_A  <= '0;
              RB2_D  <= word0_new;
            end else begin
              state <= IDLE;
            end
          end else begin
            state <= sen ? IDLE : RECV;
          end
        end
        WRITE: begin
          if (RB2_A == 5'(NWORD - 1)) begin
            RB2_RW <= 1'b1;
            RB2_A  <= '0;
`ifdef RB2_VERIFY_EN
            state  <= VERIFY;
            vcnt   <= '0;
`else
            state  <= DONE;
            done   <= 1'b1;
`endif
          end else begin
            RB2_A <= RB2_A + 5'd1;
            RB2_D <= col_buf[RB2_A + 5'd1];
          end
        end
`ifdef RB2_VERIFY_EN
        VERIFY: begin
          // Read data lags the address by one edge, so compare word vcnt-1.
          if (vcnt != 5'd0 && RB2_Q != col_buf[vcnt - 5'd1]) err <= 1'b1;
          if (vcnt < 5'(NWORD - 1)) RB2_A <= vcnt + 5'd1;
          if (vcnt == 5'(NWORD)) begin
            state <= DONE;
            done  <= 1'b1;
            RB2_A <= '0;
          end
          vcnt <= vcnt + 5'd1;
        end
`endif
        DONE: begin
          done   <= 1'b1;
          RB2_RW <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
